// File: rtl/serialize_controller.sv
// Valid/ready parallel-to-serial sequencer: loads a word, shifts it out MSB-first with frame flags.
// Optional feature: define PARITY_EN to append one parity bit per frame (sense chosen by ODD_PARITY).
module serialize_controller #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             load_shift,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  if (WIDTH < 2 || GAP_CYCLES > 255 || ODD_PARITY > 1) begin : g_param_check
    $error("serialize_controller: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef PARITY_EN
    PARITY = 2'd2,
`endif
    GAP    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
`ifdef PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic accept;
  logic last_data_bit;
  logic frame_done;

  assign last_data_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);

  always_comb begin
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = shreg_q[WIDTH-1];
`ifndef PARITY_EN
        frame_end    = last_data_bit;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        serial_valid = 1'b1;
        serial_out   = parity_q;
        frame_end    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign frame_start = (state_q == SHIFT) && (bit_cnt_q == '0);
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_end && serial_ready;

  // With no gap, a word may load on the very cycle the frame's last bit is taken.
  assign in_ready   = !reset && ((state_q == IDLE) || ((GAP_CYCLES == 0) && frame_done));
  assign accept     = in_valid && in_ready;
  assign load_shift = accept;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef PARITY_EN
    parity_d  = parity_q;
`endif

    if ((state_q == SHIFT) && serial_ready) begin
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

`ifdef PARITY_EN
    if (last_data_bit && serial_ready) begin
      state_d = PARITY;
    end
`endif

    if (frame_done) begin
      if (GAP_CYCLES != 0) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end else begin
        state_d = IDLE;
      end
    end

    if (state_q == GAP) begin
      if (gap_cnt_q == GAP_LAST) begin
        state_d   = IDLE;
        gap_cnt_d = '0;
      end else begin
        gap_cnt_d = gap_cnt_q + 8'd1;
      end
    end

    // Accept wins over the end-of-frame transition so back-to-back frames have no bubble.
    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = in_data;
      bit_cnt_d = '0;
`ifdef PARITY_EN
      parity_d  = (^in_data) ^ (ODD_PARITY != 0);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
